vc_switch_n: RTL and testbench

Parametrised successor of the two-VC / two-destination classification path. Accepts payload words tagged with a class (virtual channel) and a destination, buffers them per class in NUM_VC virtual-channel FIFOs, arbitrates among VCs under destination back-pressure, and routes each granted word into one of NUM_DEST destination FIFOs popped by the downstream serialisers. Single-clock; the serialisers and any clk_8f domain stay outside this block.

---
 rtl/vc_switch_n.sv | 228 ++++++++++++++++++++++
 tb/tb_vc_switch_n.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_switch_n.sv
// vc_switch_n: per-class VC FIFOs arbitrated into per-destination FIFOs under back-pressure.
// Define VC_RR_ARB_EN for a round-robin VC arbiter; otherwise lowest VC index wins.
module vc_switch_n #(
    parameter int unsigned PAYLOAD  = 8,
    parameter int unsigned NUM_VC   = 2,
    parameter int unsigned NUM_DEST = 2,
    parameter int unsigned VC_DEPTH = 16,
    parameter int unsigned D_DEPTH  = 4,
    localparam int unsigned VCW     = $clog2(NUM_VC),
    localparam int unsigned DW      = $clog2(NUM_DEST),
    localparam int unsigned WORD    = DW + VCW + PAYLOAD,
    localparam int unsigned VCCW    = $clog2(VC_DEPTH + 1),
    localparam int unsigned DCW     = $clog2(D_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     valid_in,
    input  logic [VCW-1:0]           vc_class,
    input  logic [DW-1:0]            dest,
    input  logic [PAYLOAD-1:0]       datain,
    input  logic [VCCW-1:0]          afVC,
    input  logic [VCCW-1:0]          aeVC,
    input  logic [DCW-1:0]           afD,
    input  logic [DCW-1:0]           aeD,
    input  logic [NUM_DEST-1:0]      pop_d,
    output logic [NUM_DEST*WORD-1:0] dataout_d,
    output logic [NUM_DEST-1:0]      valid_out_d,
    output logic [NUM_DEST-1:0]      empty_d,
    output logic [NUM_DEST-1:0]      pause_d,
    output logic [NUM_VC-1:0]        pause_vc,
    output logic [NUM_VC-1:0]        aempty_vc,
    output logic [NUM_VC-1:0]        error_vc,
    output logic [NUM_DEST-1:0]      error_d,
    output logic                     idle
);

    localparam int unsigned VCAW = $clog2(VC_DEPTH);
    localparam int unsigned DAW  = $clog2(D_DEPTH);

    // Input stage
    logic            in_vld_q;
    logic [WORD-1:0] in_word_q;
    logic [DW-1:0]   in_dest;
    logic [VCW-1:0]  in_cls;

    // VC FIFOs
    logic [WORD-1:0] vc_mem_q [NUM_VC][VC_DEPTH];
    logic [VCAW-1:0] vc_wr_q  [NUM_VC];
    logic [VCAW-1:0] vc_rd_q  [NUM_VC];
    logic [VCCW-1:0] vc_cnt_q [NUM_VC];
    logic [NUM_VC-1:0] error_vc_q;
    logic [WORD-1:0] vc_head   [NUM_VC];
    logic [DW-1:0]   head_dest [NUM_VC];
    logic [NUM_VC-1:0] vc_push, vc_ovf, vc_elig, vc_pop;

    // Arbiter
    logic [VCW-1:0] arb_base, arb_idx, gnt_idx;
    logic           gnt_vld;

    // Route register
    logic            rt_vld_q;
    logic [WORD-1:0] rt_word_q;
    logic [DW-1:0]   rt_dest;

    // Destination FIFOs
    logic [WORD-1:0] d_mem_q [NUM_DEST][D_DEPTH];
    logic [DAW-1:0]  d_wr_q  [NUM_DEST];
    logic [DAW-1:0]  d_rd_q  [NUM_DEST];
    logic [DCW-1:0]  d_cnt_q [NUM_DEST];
    logic [WORD-1:0] dout_q  [NUM_DEST];
    logic [NUM_DEST-1:0] vout_q, error_d_q;
    logic [NUM_DEST-1:0] d_push, d_pop, d_udf;

    // Almost-empty threshold of the destination FIFOs has no consumer in this block.
    logic unused_aed;
    assign unused_aed = ^aeD;

    assign in_dest = in_word_q[WORD-1 -: DW];
    assign in_cls  = in_word_q[PAYLOAD +: VCW];
    assign rt_dest = rt_word_q[WORD-1 -: DW];

    always_comb begin
        vc_push = '0;
        vc_ovf  = '0;
        vc_elig = '0;
        for (int unsigned k = 0; k < NUM_VC; k++) begin
            vc_head[k]   = vc_mem_q[k][vc_rd_q[k]];
            head_dest[k] = vc_head[k][WORD-1 -: DW];
            if (in_vld_q && in_cls == VCW'(k)) begin
                if (vc_cnt_q[k] == VCCW'(VC_DEPTH)) vc_ovf[k] = 1'b1;
                else                                vc_push[k] = 1'b1;
            end
            // A word already in flight to a destination one short of afD uses its last slot.
            vc_elig[k] = (vc_cnt_q[k] != '0) && !pause_d[head_dest[k]] &&
                         !(rt_vld_q && rt_dest == head_dest[k] &&
                           (d_cnt_q[head_dest[k]] + DCW'(1)) == afD);
        end
    end

`ifdef VC_RR_ARB_EN
    logic [VCW-1:0] rr_ptr_q;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            rr_ptr_q <= '0;
        end else if (gnt_vld) begin
            rr_ptr_q <= gnt_idx + VCW'(1);
        end
    end

    assign arb_base = rr_ptr_q;
`else
    assign arb_base = '0;
`endif

    // First eligible VC scanning upward from arb_base, wrapping modulo NUM_VC.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        arb_idx = '0;
        for (int unsigned o = 0; o < NUM_VC; o++) begin
            arb_idx = arb_base + VCW'(o);
            if (!gnt_vld && vc_elig[arb_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = arb_idx;
            end
        end
        vc_pop = '0;
        for (int unsigned k = 0; k < NUM_VC; k++) begin
            vc_pop[k] = gnt_vld && gnt_idx == VCW'(k);
        end
    end

    always_comb begin
        d_push = '0;
        d_pop  = '0;
        d_udf  = '0;
        for (int unsigned i = 0; i < NUM_DEST; i++) begin
            d_push[i] = rt_vld_q && rt_dest == DW'(i);
            d_pop[i]  = pop_d[i] && d_cnt_q[i] != '0;
            d_udf[i]  = pop_d[i] && d_cnt_q[i] == '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            in_vld_q   <= 1'b0;
            in_word_q  <= '0;
            rt_vld_q   <= 1'b0;
            rt_word_q  <= '0;
            error_vc_q <= '0;
            error_d_q  <= '0;
            vout_q     <= '0;
            for (int unsigned k = 0; k < NUM_VC; k++) begin
                vc_wr_q[k]  <= '0;
                vc_rd_q[k]  <= '0;
                vc_cnt_q[k] <= '0;
            end
            for (int unsigned i = 0; i < NUM_DEST; i++) begin
                d_wr_q[i]  <= '0;
                d_rd_q[i]  <= '0;
                d_cnt_q[i] <= '0;
                dout_q[i]  <= '0;
            end
        end else begin
            in_vld_q <= valid_in;
            if (valid_in) in_word_q <= {dest, vc_class, datain};

            rt_vld_q <= gnt_vld;
            if (gnt_vld) rt_word_q <= vc_head[gnt_idx];

            error_vc_q <= error_vc_q | vc_ovf;
            error_d_q  <= error_d_q | d_udf;
            vout_q     <= d_pop;

            for (int unsigned k = 0; k < NUM_VC; k++) begin
                if (vc_push[k]) vc_wr_q[k] <= vc_wr_q[k] + VCAW'(1);
                if (vc_pop[k])  vc_rd_q[k] <= vc_rd_q[k] + VCAW'(1);
                if (vc_push[k] && !vc_pop[k])      vc_cnt_q[k] <= vc_cnt_q[k] + VCCW'(1);
                else if (!vc_push[k] && vc_pop[k]) vc_cnt_q[k] <= vc_cnt_q[k] - VCCW'(1);
            end

            for (int unsigned i = 0; i < NUM_DEST; i++) begin
                if (d_push[i]) d_wr_q[i] <= d_wr_q[i] + DAW'(1);
                if (d_pop[i]) begin
                    d_rd_q[i] <= d_rd_q[i] + DAW'(1);
                    dout_q[i] <= d_mem_q[i][d_rd_q[i]];
                end
                if (d_push[i] && !d_pop[i])      d_cnt_q[i] <= d_cnt_q[i] + DCW'(1);
                else if (!d_push[i] && d_pop[i]) d_cnt_q[i] <= d_cnt_q[i] - DCW'(1);
            end
        end
    end

    // Storage arrays carry no reset; pointers and counts define their contents.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NUM_VC; k++) begin
            if (reset_L && vc_push[k]) vc_mem_q[k][vc_wr_q[k]] <= in_word_q;
        end
        for (int unsigned i = 0; i < NUM_DEST; i++) begin
            if (reset_L && d_push[i]) d_mem_q[i][d_wr_q[i]] <= rt_word_q;
        end
    end

    always_comb begin
        dataout_d   = '0;
        empty_d     = '0;
        pause_d     = '0;
        pause_vc    = '0;
        aempty_vc   = '0;
        valid_out_d = vout_q;
        error_vc    = error_vc_q;
        error_d     = error_d_q;
        idle        = !in_vld_q && !rt_vld_q;
        for (int unsigned i = 0; i < NUM_DEST; i++) begin
            dataout_d[i*WORD +: WORD] = dout_q[i];
            empty_d[i] = d_cnt_q[i] == '0;
            pause_d[i] = d_cnt_q[i] >= afD;
            if (d_cnt_q[i] != '0) idle = 1'b0;
        end
        for (int unsigned k = 0; k < NUM_VC; k++) begin
            pause_vc[k]  = vc_cnt_q[k] >= afVC;
            aempty_vc[k] = vc_cnt_q[k] <= aeVC;
            if (vc_cnt_q[k] != '0) idle = 1'b0;
        end
    end

endmodule

// File: tb/tb_vc_switch_n.sv
// Randomised bench for vc_switch_n against a queue-based cycle model of the switch rules.
module tb_vc_switch_n;

    localparam int PAYLOAD  = 8;
    localparam int NUM_VC   = 2;
    localparam int NUM_DEST = 2;
    localparam int VC_DEPTH = 16;
    localparam int D_DEPTH  = 4;
    localparam int VCW      = $clog2(NUM_VC);
    localparam int DW       = $clog2(NUM_DEST);
    localparam int WORD     = DW + VCW + PAYLOAD;
    localparam int VCCW     = $clog2(VC_DEPTH + 1);
    localparam int DCW      = $clog2(D_DEPTH + 1);
`ifdef VC_RR_ARB_EN
    localparam bit RrMode = 1'b1;
`else
    localparam bit RrMode = 1'b0;
`endif

    typedef logic [WORD-1:0] word_t;

    logic                     clk = 1'b0;
    logic                     reset_L;
    logic                     valid_in;
    logic [VCW-1:0]           vc_class;
    logic [DW-1:0]            dest;
    logic [PAYLOAD-1:0]       datain;
    logic [VCCW-1:0]          afVC, aeVC;
    logic [DCW-1:0]           afD, aeD;
    logic [NUM_DEST-1:0]      pop_d;
    logic [NUM_DEST*WORD-1:0] dataout_d;
    logic [NUM_DEST-1:0]      valid_out_d, empty_d, pause_d, error_d;
    logic [NUM_VC-1:0]        pause_vc, aempty_vc, error_vc;
    logic                     idle;

    always #5 clk = ~clk;

    vc_switch_n #(
        .PAYLOAD (PAYLOAD),
        .NUM_VC  (NUM_VC),
        .NUM_DEST(NUM_DEST),
        .VC_DEPTH(VC_DEPTH),
        .D_DEPTH (D_DEPTH)
    ) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .valid_in   (valid_in),
        .vc_class   (vc_class),
        .dest       (dest),
        .datain     (datain),
        .afVC       (afVC),
        .aeVC       (aeVC),
        .afD        (afD),
        .aeD        (aeD),
        .pop_d      (pop_d),
        .dataout_d  (dataout_d),
        .valid_out_d(valid_out_d),
        .empty_d    (empty_d),
        .pause_d    (pause_d),
        .pause_vc   (pause_vc),
        .aempty_vc  (aempty_vc),
        .error_vc   (error_vc),
        .error_d    (error_d),
        .idle       (idle)
    );

    // Reference model state: plain queues per FIFO plus the two single-word stages.
    word_t m_vc [NUM_VC][$];
    word_t m_dq [NUM_DEST][$];
    bit    m_in_vld, m_rt_vld;
    word_t m_in_word, m_rt_word;
    word_t m_dout [NUM_DEST];
    bit    m_vout [NUM_DEST];
    bit    m_err_vc [NUM_VC];
    bit    m_err_d [NUM_DEST];
    int    m_rr;

    int checks;
    int failures;
    bit seen;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dest_of(input word_t w);
        return int'(w[WORD-1 -: DW]);
    endfunction

    function automatic int cls_of(input word_t w);
        return int'(w[PAYLOAD +: VCW]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_VC; k++) begin
            m_vc[k].delete();
            m_err_vc[k] = 1'b0;
        end
        for (int i = 0; i < NUM_DEST; i++) begin
            m_dq[i].delete();
            m_dout[i]  = '0;
            m_vout[i]  = 1'b0;
            m_err_d[i] = 1'b0;
        end
        m_in_vld  = 1'b0;
        m_rt_vld  = 1'b0;
        m_in_word = '0;
        m_rt_word = '0;
        m_rr      = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int    gnt;
        int    base;
        int    k;
        int    h;
        int    c;
        word_t w;
        bit    full [NUM_VC];
        if (!reset_L) begin
            model_reset();
            return;
        end
        base = RrMode ? m_rr : 0;
        gnt  = -1;
        for (int o = 0; o < NUM_VC; o++) begin
            k = (base + o) % NUM_VC;
            if (gnt < 0 && m_vc[k].size() > 0) begin
                w = m_vc[k][0];
                h = dest_of(w);
                if (m_dq[h].size() < int'(afD) &&
                    !(m_rt_vld && dest_of(m_rt_word) == h && m_dq[h].size() == int'(afD) - 1))
                    gnt = k;
            end
        end
        for (int i = 0; i < NUM_DEST; i++) begin
            m_vout[i] = 1'b0;
            if (pop_d[i]) begin
                if (m_dq[i].size() > 0) begin
                    m_dout[i] = m_dq[i].pop_front();
                    m_vout[i] = 1'b1;
                end else begin
                    m_err_d[i] = 1'b1;
                end
            end
        end
        if (m_rt_vld) m_dq[dest_of(m_rt_word)].push_back(m_rt_word);
        for (int j = 0; j < NUM_VC; j++) full[j] = m_vc[j].size() >= VC_DEPTH;
        m_rt_vld = gnt >= 0;
        if (gnt >= 0) begin
            m_rt_word = m_vc[gnt].pop_front();
            m_rr = (gnt + 1) % NUM_VC;
        end
        if (m_in_vld) begin
            c = cls_of(m_in_word);
            if (full[c]) m_err_vc[c] = 1'b1;
            else         m_vc[c].push_back(m_in_word);
        end
        m_in_vld = valid_in;
        if (valid_in) m_in_word = {dest, vc_class, datain};
    endtask

    task automatic compare_all();
        logic [NUM_DEST-1:0] e_vout, e_empty, e_pause, e_errd;
        logic [NUM_VC-1:0]   e_pvc, e_ae, e_errvc;
        logic                e_idle;
        e_idle = !m_in_vld && !m_rt_vld;
        for (int i = 0; i < NUM_DEST; i++) begin
            e_vout[i]  = m_vout[i];
            e_empty[i] = m_dq[i].size() == 0;
            e_pause[i] = m_dq[i].size() >= int'(afD);
            e_errd[i]  = m_err_d[i];
            if (m_dq[i].size() != 0) e_idle = 1'b0;
            check_eq("dataout_d", dataout_d[i*WORD +: WORD], m_dout[i]);
        end
        for (int k = 0; k < NUM_VC; k++) begin
            e_pvc[k]   = m_vc[k].size() >= int'(afVC);
            e_ae[k]    = m_vc[k].size() <= int'(aeVC);
            e_errvc[k] = m_err_vc[k];
            if (m_vc[k].size() != 0) e_idle = 1'b0;
        end
        check_eq("valid_out_d", valid_out_d, e_vout);
        check_eq("empty_d", empty_d, e_empty);
        check_eq("pause_d", pause_d, e_pause);
        check_eq("error_d", error_d, e_errd);
        check_eq("pause_vc", pause_vc, e_pvc);
        check_eq("aempty_vc", aempty_vc, e_ae);
        check_eq("error_vc", error_vc, e_errvc);
        check_eq("idle", idle, e_idle);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset(input int cycles);
        reset_L = 1'b0;
        repeat (cycles) tick();
        reset_L = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_L  = 1'b0;
        valid_in = 1'b1;
        vc_class = '0;
        dest     = '0;
        datain   = 8'h5A;
        pop_d    = '0;
        afVC     = VCCW'(12);
        aeVC     = VCCW'(2);
        afD      = DCW'(3);
        aeD      = DCW'(1);
        model_reset();

        // Reset held with valid_in asserted.
        repeat (4) tick();
        check_eq("rst_idle", idle, 1'b1);
        check_eq("rst_empty_d", empty_d, {NUM_DEST{1'b1}});
        check_eq("rst_aempty_vc", aempty_vc, {NUM_VC{1'b1}});
        check_eq("rst_dataout", dataout_d, '0);
        reset_L  = 1'b1;
        valid_in = 1'b0;
        tick();

        // Single word class 1 dest 0 payload A5.
        valid_in = 1'b1;
        vc_class = VCW'(1);
        dest     = DW'(0);
        datain   = 8'hA5;
        tick();
        valid_in = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            if (!empty_d[0]) seen = 1'b1;
            else tick();
        end
        check_eq("single_arrive", seen, 1'b1);
        pop_d = 2'b01;
        tick();
        pop_d = 2'b00;
        check_eq("single_valid", valid_out_d[0], 1'b1);
        check_eq("single_word", dataout_d[WORD-1:0], 10'h1A5);
        tick();

        // Pop on empty destination 1: sticky underflow.
        pop_d = 2'b10;
        tick();
        pop_d = 2'b00;
        check_eq("udf_valid", valid_out_d[1], 1'b0);
        repeat (3) tick();
        check_eq("udf_sticky", error_d[1], 1'b1);
        do_reset(2);
        tick();
        check_eq("udf_cleared", error_d, '0);

        // Stream to VC0 / dest 1 with no pops: dest pauses at afD, VC0 overflows.
        for (int n = 0; n < 22; n++) begin
            valid_in = 1'b1;
            vc_class = VCW'(0);
            dest     = DW'(1);
            datain   = PAYLOAD'(n);
            tick();
        end
        valid_in = 1'b0;
        repeat (4) tick();
        check_eq("fill_err_vc0", error_vc[0], 1'b1);
        check_eq("fill_pause_vc0", pause_vc[0], 1'b1);
        check_eq("fill_pause_d1", pause_d[1], 1'b1);
        check_eq("fill_no_err_d", error_d, '0);
        pop_d = 2'b10;
        repeat (40) tick();
        pop_d = 2'b00;
        repeat (3) tick();

        // Two VCs to distinct destinations with pops always on.
        do_reset(2);
        pop_d = 2'b11;
        for (int n = 0; n < 8; n++) begin
            valid_in = 1'b1;
            vc_class = VCW'(n % 2);
            dest     = DW'(n % 2);
            datain   = PAYLOAD'(8'h40 + n);
            tick();
        end
        valid_in = 1'b0;
        repeat (20) tick();

        // Random traffic, thresholds re-chosen under reset, one reset mid-traffic.
        for (int seg = 0; seg < 6; seg++) begin
            int pop_pct;
            afD     = DCW'($urandom_range(1, D_DEPTH - 1));
            aeD     = DCW'($urandom_range(0, D_DEPTH));
            afVC    = VCCW'($urandom_range(1, VC_DEPTH));
            aeVC    = VCCW'($urandom_range(0, VC_DEPTH));
            pop_pct = 20 + 15 * seg;
            do_reset(2);
            for (int n = 0; n < 500; n++) begin
                valid_in = ($urandom % 4) != 0;
                vc_class = VCW'($urandom);
                dest     = DW'($urandom);
                datain   = PAYLOAD'($urandom);
                for (int i = 0; i < NUM_DEST; i++) pop_d[i] = ($urandom % 100) < pop_pct;
                if (seg == 3 && n == 250) reset_L = 1'b0;
                tick();
                reset_L = 1'b1;
            end
        end

        // Drain everything.
        valid_in = 1'b0;
        pop_d    = '1;
        repeat (80) tick();
        check_eq("drain_idle", idle, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
